mdio_responder: RTL

//  Clause-22 MDIO target (PHY side) of the management link: decodes MDC/MDIO frames from
//  an MDIO master and serves them from a host register port. Used as an FPGA-resident
//  PHY register model and as the bench partner for the management-master block.

---
 rtl/mdio_pkg.sv | 23 ++
 rtl/mdio_edge_sync.sv | 33 +++
 rtl/mdio_responder.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/mdio_pkg.sv
// Shared constants and state type for the Clause-22 MDIO responder.
package mdio_pkg;

    localparam int PHYAD_W      = 5;
    localparam int REGAD_W      = 5;
    localparam int DATA_W       = 16;
    localparam int PREAMBLE_LEN = 32;

    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] TA_WRITE = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ST,
        S_OP,
        S_PHYAD,
        S_REGAD,
        S_TA,
        S_DATA
    } state_t;

endpackage

// File: rtl/mdio_edge_sync.sv
// Synchronises MDC/MDIO into the clk domain and flags MDC rising edges.
module mdio_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic mdc_in,
    input  logic mdio_in,
    output logic mdc_re,
    output logic mdio_s
);

    logic [SYNC_STAGES-1:0] mdc_sync;
    logic [SYNC_STAGES-1:0] mdio_sync;
    logic                   mdc_prev;

    // Resetting MDC history high means a clock already high at reset release is not an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            mdc_sync  <= '1;
            mdio_sync <= '1;
            mdc_prev  <= 1'b1;
        end else begin
            mdc_sync  <= {mdc_sync[SYNC_STAGES-2:0], mdc_in};
            mdio_sync <= {mdio_sync[SYNC_STAGES-2:0], mdio_in};
            mdc_prev  <= mdc_sync[SYNC_STAGES-1];
        end
    end

    assign mdc_re = mdc_sync[SYNC_STAGES-1] & ~mdc_prev;
    assign mdio_s = mdio_sync[SYNC_STAGES-1];

endmodule

// File: rtl/mdio_responder.sv
// Clause-22 MDIO target serving frames from a host register port.
// Define MDIO_PREAMBLE_CHECK_EN to demand a full 32-bit preamble before ST.
import mdio_pkg::*;

module mdio_responder #(
    parameter logic [4:0] PHY_ADDR    = 5'd1,
    parameter int         SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mdc_in,
    input  logic        mdio_in,
    output logic        mdio_out,
    output logic        mdio_oe,
    output logic        rd_req,
    output logic [4:0]  rd_addr,
    input  logic [15:0] rd_data,
    output logic        wr_strobe,
    output logic [4:0]  wr_addr,
    output logic [15:0] wr_data,
    output logic        frame_err,
    output logic        busy
);

    logic              mdc_re;
    logic              mdio_s;
    state_t            state;
    logic [5:0]        ones_cnt;
    logic [4:0]        bit_cnt;
    logic              is_read;
    logic              op_hi;
    logic [4:0]        phyad;
    logic [4:0]        regad;
    logic [DATA_W-1:0] shift;
    logic              match;

    mdio_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk    (clk),
        .rst    (rst),
        .mdc_in (mdc_in),
        .mdio_in(mdio_in),
        .mdc_re (mdc_re),
        .mdio_s (mdio_s)
    );

    assign match = (phyad == PHY_ADDR);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            ones_cnt  <= '0;
            bit_cnt   <= '0;
            is_read   <= 1'b0;
            op_hi     <= 1'b0;
            phyad     <= '0;
            regad     <= '0;
            shift     <= '0;
            mdio_out  <= 1'b1;
            mdio_oe   <= 1'b0;
            rd_req    <= 1'b0;
            rd_addr   <= '0;
            wr_strobe <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            rd_req    <= 1'b0;
            wr_strobe <= 1'b0;
            frame_err <= 1'b0;
            if (mdc_re) begin
                case (state)
                    S_IDLE: begin
                        if (mdio_s) begin
                            if (ones_cnt != 6'(PREAMBLE_LEN))
                                ones_cnt <= ones_cnt + 6'd1;
                        end else begin
`ifdef MDIO_PREAMBLE_CHECK_EN
                            if (ones_cnt == 6'(PREAMBLE_LEN)) begin
                                state <= S_ST;
                                busy  <= 1'b1;
                            end else begin
                                frame_err <= 1'b1;
                            end
                            ones_cnt <= '0;
`else
                            if (ones_cnt != 6'd0) begin
                                state    <= S_ST;
                                busy     <= 1'b1;
                                ones_cnt <= '0;
                            end
`endif
                        end
                    end
                    S_ST: begin
                        if (mdio_s) begin
                            state   <= S_OP;
                            bit_cnt <= '0;
                        end else begin
                            state     <= S_IDLE;
                            busy      <= 1'b0;
                            frame_err <= 1'b1;
                        end
                    end
                    S_OP: begin
                        if (bit_cnt == 5'd0) begin
                            op_hi   <= mdio_s;
                            bit_cnt <= 5'd1;
                        end else if ({op_hi, mdio_s} == OP_READ || {op_hi, mdio_s} == OP_WRITE) begin
                            is_read <= ({op_hi, mdio_s} == OP_READ);
                            state   <= S_PHYAD;
                            bit_cnt <= '0;
                        end else begin
                            state     <= S_IDLE;
                            busy      <= 1'b0;
                            frame_err <= 1'b1;
                        end
                    end
                    S_PHYAD: begin
                        phyad <= {phyad[PHYAD_W-2:0], mdio_s};
                        if (bit_cnt == 5'(PHYAD_W - 1)) begin
                            state   <= S_REGAD;
                            bit_cnt <= '0;
                        end else begin
                            bit_cnt <= bit_cnt + 5'd1;
                        end
                    end
                    S_REGAD: begin
                        regad <= {regad[REGAD_W-2:0], mdio_s};
                        if (bit_cnt == 5'(REGAD_W - 1)) begin
                            state   <= S_TA;
                            bit_cnt <= '0;
                            if (is_read && match) begin
                                rd_req  <= 1'b1;
                                rd_addr <= {regad[REGAD_W-2:0], mdio_s};
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 5'd1;
                        end
                    end
                    // Read: take the bus for TA bit 2 (driven 0), then present D15 after TA ends.
                    S_TA: begin
                        if (!is_read && mdio_s != TA_WRITE[1 - bit_cnt[0]]) begin
                            state     <= S_IDLE;
                            busy      <= 1'b0;
                            frame_err <= 1'b1;
                        end else if (bit_cnt == 5'd0) begin
                            bit_cnt <= 5'd1;
                            if (is_read && match) begin
                                shift    <= rd_data;
                                mdio_out <= 1'b0;
                                mdio_oe  <= 1'b1;
                            end
                        end else begin
                            state   <= S_DATA;
                            bit_cnt <= '0;
                            if (is_read && match) begin
                                mdio_out <= shift[DATA_W-1];
                                shift    <= {shift[DATA_W-2:0], 1'b0};
                            end
                        end
                    end
                    S_DATA: begin
                        if (!is_read)
                            shift <= {shift[DATA_W-2:0], mdio_s};
                        if (bit_cnt == 5'(DATA_W - 1)) begin
                            state    <= S_IDLE;
                            busy     <= 1'b0;
                            mdio_oe  <= 1'b0;
                            mdio_out <= 1'b1;
                            if (!is_read && match) begin
                                wr_strobe <= 1'b1;
                                wr_addr   <= regad;
                                wr_data   <= {shift[DATA_W-2:0], mdio_s};
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 5'd1;
                            if (is_read && match) begin
                                mdio_out <= shift[DATA_W-1];
                                shift    <= {shift[DATA_W-2:0], 1'b0};
                            end
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
